// File: rtl/alu_exec_unit_if.sv
// Operand/result handshake bundle between the operand demux, the execute unit and writeback.
interface alu_exec_unit_if #(
  parameter int WIDTH = 16
);
  logic [1:0]       op_opcode;
  logic [WIDTH-1:0] rs1_val;
  logic [WIDTH-1:0] rs2_val;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] result;
  logic             flag;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output op_opcode, rs1_val, rs2_val, in_valid, out_ready,
    input  in_ready, result, flag, out_valid
  );

  modport slave (
    input  op_opcode, rs1_val, rs2_val, in_valid, out_ready,
    output in_ready, result, flag, out_valid
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute stage: 1-cycle ADD/SUB, iterative shift-add MUL and restoring DIV, one result per handshake.
// Define ALU_FAST_MUL_EN to replace the iterative MUL with a single-cycle multiplier.
module alu_exec_unit #(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  alu_exec_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
`ifndef ALU_FAST_MUL_EN
    MUL_ITER = 2'd1,
`endif
    DIV_ITER = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               flag_q, flag_d;

  // acc holds {remainder, dividend/quotient} for DIV and {partial product, multiplier} for MUL
  logic [WIDTH:0]     div_shift;
  logic               div_take;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_step;
  logic               last_iter;

  always_comb begin
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_take  = (div_shift >= {1'b0, opnd_q});
    div_diff  = div_shift - {1'b0, opnd_q};
    div_step  = div_take ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                         : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    last_iter = (cnt_q == CW'(WIDTH - 1));
  end

`ifdef ALU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = (2*WIDTH)'(bus.rs1_val) * (2*WIDTH)'(bus.rs2_val);
`else
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flag_d   = flag_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          cnt_d = '0;
          case (bus.op_opcode)
            2'd0: begin
              {flag_d, result_d} = {1'b0, bus.rs1_val} + {1'b0, bus.rs2_val};
              state_d = DONE;
            end
            2'd1: begin
              result_d = bus.rs1_val - bus.rs2_val;
              flag_d   = (bus.rs1_val < bus.rs2_val);
              state_d  = DONE;
            end
            2'd2: begin
`ifdef ALU_FAST_MUL_EN
              result_d = fast_prod[WIDTH-1:0];
              flag_d   = |fast_prod[2*WIDTH-1:WIDTH];
              state_d  = DONE;
`else
              opnd_d  = bus.rs1_val;
              acc_d   = {{WIDTH{1'b0}}, bus.rs2_val};
              state_d = MUL_ITER;
`endif
            end
            default: begin
              if (bus.rs2_val == '0) begin
                result_d = '1;
                flag_d   = 1'b1;
                state_d  = DONE;
              end else begin
                opnd_d  = bus.rs2_val;
                acc_d   = {{WIDTH{1'b0}}, bus.rs1_val};
                state_d = DIV_ITER;
              end
            end
          endcase
        end
      end
`ifndef ALU_FAST_MUL_EN
      MUL_ITER: begin
        acc_d = mul_step;
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          result_d = mul_step[WIDTH-1:0];
          flag_d   = |mul_step[2*WIDTH-1:WIDTH];
          state_d  = DONE;
        end
      end
`endif
      DIV_ITER: begin
        acc_d = div_step;
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          result_d = div_step[WIDTH-1:0];
          flag_d   = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flag_q   <= flag_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.flag      = flag_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus randomized ops against an arithmetic model.
module tb_alu_exec_unit;

  localparam int W = 16;
`ifdef ALU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif
  localparam int DIV_LAT = W + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_exec_unit_if #(.WIDTH(W)) bus ();
  alu_exec_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  // Expected result/flag/latency straight from the arithmetic definition of each opcode
  function automatic void model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic f, output int lat);
    longint unsigned ua, ub, p;
    ua = a; ub = b;
    case (op)
      2'd0: begin p = ua + ub; r = 16'(p % 65536); f = (p > 65535); lat = 1; end
      2'd1: begin r = 16'((ua + 65536 - ub) % 65536); f = (ua < ub); lat = 1; end
      2'd2: begin p = ua * ub; r = 16'(p % 65536); f = ((p / 65536) != 0); lat = MUL_LAT; end
      default: begin
        if (ub == 0) begin r = 16'hFFFF; f = 1'b1; lat = 1; end
        else begin r = 16'(ua / ub); f = 1'b0; lat = DIV_LAT; end
      end
    endcase
  endfunction

  // Issues one op from IDLE and returns cycles until out_valid (-1 on timeout); leaves result undrained
  task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input bit hold_valid, output int lat);
    @(negedge clk);
    bus.op_opcode = op; bus.rs1_val = a; bus.rs2_val = b;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    if (hold_valid) begin
      bus.op_opcode = 2'($urandom_range(0, 3));
      bus.rs1_val = 16'($urandom); bus.rs2_val = 16'($urandom);
    end else begin
      bus.in_valid = 1'b0;
    end
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.out_valid) lat = -1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.result !== 16'h0) begin failures++; $display("[TB] FAIL reset_result got=%h exp=0000", bus.result); end
    checks++; if (bus.flag !== 1'b0) begin failures++; $display("[TB] FAIL reset_flag got=%b exp=0", bus.flag); end
  endtask

  task automatic test_directed();
    logic [1:0]  ops [7] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    logic [15:0] as  [7] = '{16'hFFFF, 16'h0003, 16'h0009, 16'h0100, 16'h0012, 16'd100, 16'h1234};
    logic [15:0] bs  [7] = '{16'h0001, 16'h0005, 16'h0004, 16'h0100, 16'h0003, 16'd7, 16'h0000};
    logic [15:0] er [7] = '{16'h0000, 16'hFFFE, 16'h0005, 16'h0000, 16'h0036, 16'd14, 16'hFFFF};
    logic        ef [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int el [7] = '{1, 1, 1, MUL_LAT, MUL_LAT, DIV_LAT, 1};
    int lat;
    for (int i = 0; i < 7; i++) begin
      run_op(ops[i], as[i], bs[i], 1'b0, lat);
      checks++; if (lat != el[i]) begin failures++; $display("[TB] FAIL dir%0d_latency got=%0d exp=%0d", i, lat, el[i]); end
      checks++; if (bus.result !== er[i]) begin failures++; $display("[TB] FAIL dir%0d_result got=%h exp=%h", i, bus.result, er[i]); end
      checks++; if (bus.flag !== ef[i]) begin failures++; $display("[TB] FAIL dir%0d_flag got=%b exp=%b", i, bus.flag, ef[i]); end
      drain();
      checks++; if (bus.result !== er[i]) begin failures++; $display("[TB] FAIL dir%0d_result_hold got=%h exp=%h", i, bus.result, er[i]); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(2'd0, 16'd2, 16'd3, 1'b0, lat);
    checks++; if (lat != 1) begin failures++; $display("[TB] FAIL bp_latency got=%0d exp=1", lat); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.result !== 16'd5 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL bp_hold%0d got result=%h valid=%b ready=%b exp 0005/1/0", c, bus.result, bus.out_valid, bus.in_ready);
      end
    end
    drain();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_drain_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_drain_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_reset_abort();
    int lat;
    @(negedge clk);
    bus.op_opcode = 2'd3; bus.rs1_val = 16'hFFFF; bus.rs2_val = 16'd3; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL abort_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL abort_ready got=%b exp=1", bus.in_ready); end
    @(negedge clk);
    rst = 1'b0;
    run_op(2'd0, 16'd1, 16'd1, 1'b0, lat);
    checks++; if (lat != 1 || bus.result !== 16'd2) begin failures++; $display("[TB] FAIL abort_add got lat=%0d result=%h exp 1/0002", lat, bus.result); end
    drain();
    run_op(2'd3, 16'hFFFF, 16'd3, 1'b0, lat);
    checks++; if (lat != DIV_LAT || bus.result !== 16'h5555) begin failures++; $display("[TB] FAIL abort_div got lat=%0d result=%h exp %0d/5555", lat, bus.result, DIV_LAT); end
    drain();
  endtask

  task automatic test_busy_ignore();
    int lat;
    logic [15:0] r; logic f; int el;
    model(2'd2, 16'h00AB, 16'h0102, r, f, el);
    run_op(2'd2, 16'h00AB, 16'h0102, 1'b1, lat);
    checks++; if (lat != el) begin failures++; $display("[TB] FAIL busy_latency got=%0d exp=%0d", lat, el); end
    checks++; if (bus.result !== r || bus.flag !== f) begin failures++; $display("[TB] FAIL busy_result got=%h/%b exp=%h/%b", bus.result, bus.flag, r, f); end
    drain();
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL busy_idle got valid=%b ready=%b exp 0/1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_random();
    logic [1:0] op; logic [15:0] a, b, r; logic f; int el, lat, waitc;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0: b = 16'h0;
        1: b = 16'($urandom_range(1, 15));
        default: b = 16'($urandom);
      endcase
      model(op, a, b, r, f, el);
      run_op(op, a, b, 1'b0, lat);
      waitc = $urandom_range(0, 3);
      repeat (waitc) @(posedge clk);
      #1;
      checks++;
      if (lat != el || bus.result !== r || bus.flag !== f || bus.out_valid !== 1'b1) begin
        failures++;
        $display("[TB] FAIL rand%0d op=%0d a=%h b=%h got lat=%0d res=%h flag=%b valid=%b exp lat=%0d res=%h flag=%b",
                 i, op, a, b, lat, bus.result, bus.flag, bus.out_valid, el, r, f);
      end
      drain();
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.op_opcode = 2'd0; bus.rs1_val = '0; bus.rs2_val = '0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_directed();
    test_backpressure();
    test_reset_abort();
    test_busy_ignore();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
